// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: fetch FSM encoding, the NOP word used for
// IF/ID bubbles and flushes, and the PC-to-memory-address mapping.
package if_fetch_unit_pkg;

    typedef enum logic {
        FETCH_REQ  = 1'b0,
        FETCH_HOLD = 1'b1
    } fetch_state_t;

    // sll $0,$0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    function automatic logic [31:0] word_addr(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_ifid_pipe_reg.sv
// IF/ID pipeline register: instruction, its address and a valid bit, with
// write enable and a flush that forces a bubble.
module if_fetch_unit_ifid_pipe_reg #(
    parameter logic [31:0] NOP_WORD = if_fetch_unit_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_enable,
    input  logic        flush,
    input  logic        load_valid,
    input  logic [31:0] data,
    input  logic [31:0] pc,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        valid
);

    // Flush beats any load; a write without a real word becomes a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction <= NOP_WORD;
            pc_out      <= 32'h0000_0000;
            valid       <= 1'b0;
        end else if (flush) begin
            instruction <= NOP_WORD;
            pc_out      <= 32'h0000_0000;
            valid       <= 1'b0;
        end else if (write_enable) begin
            if (load_valid) begin
                instruction <= data;
                pc_out      <= pc;
                valid       <= 1'b1;
            end else begin
                instruction <= NOP_WORD;
                pc_out      <= 32'h0000_0000;
                valid       <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, instruction-memory handshake, redirect squash
// and hold buffer, feeding the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = if_fetch_unit_pkg::NOP_WORD
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        PC_WriteEnable,
    input  logic        IFIDWriteEnable,
    input  logic        IFIDFlush,
    input  logic        Branch,
    input  logic [31:0] BranchDest,
    input  logic        Jump,
    input  logic [31:0] JumpDest,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [31:0] IMemData,
    output logic [31:0] Instruction,
    output logic [31:0] PC_Out,
    output logic        IFIDValid,
    output logic        FetchStall
);
    import if_fetch_unit_pkg::*;

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  hold_buf;
    logic [31:0]  squash_target;
    logic         squash;

    logic [31:0]  target;
    logic         redirect;
    logic         advance;
    logic         deliver;
    logic [31:0]  deliver_word;

    assign target   = Jump ? JumpDest : BranchDest;
    assign redirect = Branch | Jump;
    assign advance  = PC_WriteEnable & IFIDWriteEnable;

    // Decide whether a real instruction moves into IF/ID this cycle.
    always_comb begin
        deliver      = 1'b0;
        deliver_word = IMemData;
        case (state)
            FETCH_REQ: begin
                deliver      = IMemReady & ~redirect & ~squash & advance;
                deliver_word = IMemData;
            end
            FETCH_HOLD: begin
                deliver      = ~redirect & advance;
                deliver_word = hold_buf;
            end
            default: begin
                deliver      = 1'b0;
                deliver_word = IMemData;
            end
        endcase
    end

    // Fetch FSM: the PC only moves on an accepted request so IMemAddr is stable while waiting.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state         <= FETCH_REQ;
            pc            <= RESET_PC;
            hold_buf      <= 32'h0000_0000;
            squash        <= 1'b0;
            squash_target <= 32'h0000_0000;
        end else begin
            case (state)
                FETCH_REQ: begin
                    if (!IMemReady) begin
                        if (redirect) begin
                            squash        <= 1'b1;
                            squash_target <= target;
                        end
                    end else if (redirect) begin
                        pc     <= target;
                        squash <= 1'b0;
                    end else if (squash) begin
                        pc     <= squash_target;
                        squash <= 1'b0;
                    end else if (advance) begin
                        pc <= pc + 32'd4;
                    end else begin
                        hold_buf <= IMemData;
                        state    <= FETCH_HOLD;
                    end
                end
                FETCH_HOLD: begin
                    if (redirect) begin
                        pc       <= target;
                        hold_buf <= 32'h0000_0000;
                        state    <= FETCH_REQ;
                    end else if (advance) begin
                        pc    <= pc + 32'd4;
                        state <= FETCH_REQ;
                    end
                end
                default: state <= FETCH_REQ;
            endcase
        end
    end

    // Request is dropped combinationally by reset so an in-flight fetch is abandoned at once.
    assign IMemReq    = (state == FETCH_REQ) & ~Reset;
    assign IMemAddr   = word_addr(pc);
    assign FetchStall = (state == FETCH_HOLD) | ((state == FETCH_REQ) & ~IMemReady);

    if_fetch_unit_ifid_pipe_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_ifid_pipe_reg (
        .clk          (Clock),
        .rst          (Reset),
        .write_enable (IFIDWriteEnable),
        .flush        (IFIDFlush),
        .load_valid   (deliver),
        .data         (deliver_word),
        .pc           (pc),
        .instruction  (Instruction),
        .pc_out       (PC_Out),
        .valid        (IFIDValid)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a behavioural fetch model compared every cycle,
// plus hand-computed checks for each scenario of interest.
module tb_if_fetch_unit;

    logic        Clock           = 1'b0;
    logic        Reset           = 1'b1;
    logic        PC_WriteEnable  = 1'b1;
    logic        IFIDWriteEnable = 1'b1;
    logic        IFIDFlush       = 1'b0;
    logic        Branch          = 1'b0;
    logic [31:0] BranchDest      = 32'h0;
    logic        Jump            = 1'b0;
    logic [31:0] JumpDest        = 32'h0;
    logic        IMemReady       = 1'b1;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic [31:0] IMemData;
    logic [31:0] Instruction;
    logic [31:0] PC_Out;
    logic        IFIDValid;
    logic        FetchStall;

    int n_checks = 0;
    int n_errors = 0;

    // Memory contents: address+1 everywhere except a marker word at 0x10.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_0010) ? 32'hAABB_CCDD : a + 32'd1;
    endfunction

    assign IMemData = mem_word(IMemAddr);

    always #5 Clock = ~Clock;

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .PC_WriteEnable  (PC_WriteEnable),
        .IFIDWriteEnable (IFIDWriteEnable),
        .IFIDFlush       (IFIDFlush),
        .Branch          (Branch),
        .BranchDest      (BranchDest),
        .Jump            (Jump),
        .JumpDest        (JumpDest),
        .IMemReq         (IMemReq),
        .IMemAddr        (IMemAddr),
        .IMemReady       (IMemReady),
        .IMemData        (IMemData),
        .Instruction     (Instruction),
        .PC_Out          (PC_Out),
        .IFIDValid       (IFIDValid),
        .FetchStall      (FetchStall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the fetch stage must hold, independent of how the RTL encodes it.
    logic [31:0] m_pc = 32'h0, m_buf = 32'h0, m_sq_tgt = 32'h0;
    logic [31:0] m_instr = 32'h0, m_pcout = 32'h0;
    bit          m_hold = 1'b0, m_sq = 1'b0, m_valid = 1'b0;

    task automatic model_reset();
        m_pc = 32'h0; m_buf = 32'h0; m_sq_tgt = 32'h0;
        m_instr = 32'h0; m_pcout = 32'h0;
        m_hold = 1'b0; m_sq = 1'b0; m_valid = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] tgt, word, fetched_pc;
        bit redirect, advance, have_word, deliver;
        tgt        = Jump ? JumpDest : BranchDest;
        redirect   = Branch || Jump;
        advance    = PC_WriteEnable && IFIDWriteEnable;
        have_word  = m_hold || IMemReady;
        word       = m_hold ? m_buf : mem_word({m_pc[31:2], 2'b00});
        fetched_pc = m_pc;
        deliver    = 1'b0;
        if (!have_word) begin
            if (redirect) begin m_sq = 1'b1; m_sq_tgt = tgt; end
        end else if (redirect) begin
            m_pc = tgt; m_sq = 1'b0; m_hold = 1'b0;
        end else if (m_sq) begin
            m_pc = m_sq_tgt; m_sq = 1'b0;
        end else if (advance) begin
            deliver = 1'b1; m_pc = m_pc + 32'd4; m_hold = 1'b0;
        end else begin
            m_buf = word; m_hold = 1'b1;
        end
        if (IFIDFlush || (IFIDWriteEnable && !deliver)) begin
            m_instr = 32'h0; m_pcout = 32'h0; m_valid = 1'b0;
        end else if (deliver) begin
            m_instr = word; m_pcout = fetched_pc; m_valid = 1'b1;
        end
    endtask

    // Compare process: outputs are settled at the falling edge.
    always @(negedge Clock) begin
        if (Reset) model_reset();
        chk("m_req",   32'(IMemReq),    32'(!Reset && !m_hold));
        chk("m_addr",  IMemAddr,        {m_pc[31:2], 2'b00});
        chk("m_stall", 32'(FetchStall), 32'(m_hold || !IMemReady));
        chk("m_instr", Instruction,     m_instr);
        chk("m_pcout", PC_Out,          m_pcout);
        chk("m_valid", 32'(IFIDValid),  32'(m_valid));
        if (!Reset) model_step();
    end

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: streaming after reset
        cyc(); cyc();
        Reset = 1'b0; #1;
        chk("t1_req",   32'(IMemReq),   32'd1);
        chk("t1_addr0", IMemAddr,       32'h0);
        chk("t1_valid0", 32'(IFIDValid), 32'd0);
        cyc();
        chk("t1_instr1", Instruction, 32'h1); chk("t1_pc1", PC_Out, 32'h0);
        chk("t1_v1", 32'(IFIDValid), 32'd1);  chk("t1_addr4", IMemAddr, 32'h4);
        cyc();
        chk("t1_instr5", Instruction, 32'h5); chk("t1_pc4", PC_Out, 32'h4);
        chk("t1_addr8", IMemAddr, 32'h8);
        cyc();
        chk("t1_instr9", Instruction, 32'h9); chk("t1_pc8", PC_Out, 32'h8);
        repeat (13) cyc();
        chk("t2_addr40", IMemAddr, 32'h40);

        // 2: branch with flush
        Branch = 1'b1; BranchDest = 32'h100; IFIDFlush = 1'b1;
        cyc();
        Branch = 1'b0; IFIDFlush = 1'b0;
        chk("t2_addr", IMemAddr, 32'h100); chk("t2_nop", Instruction, 32'h0);
        chk("t2_valid", 32'(IFIDValid), 32'd0);
        cyc();
        chk("t2_instr", Instruction, 32'h101); chk("t2_pc", PC_Out, 32'h100);

        // 3: jump beats branch
        Jump = 1'b1; JumpDest = 32'h200; Branch = 1'b1; BranchDest = 32'h300;
        cyc();
        Jump = 1'b0; Branch = 1'b0;
        chk("t3_addr", IMemAddr, 32'h200); chk("t3_bubble", 32'(IFIDValid), 32'd0);
        cyc();
        chk("t3_instr", Instruction, 32'h201);

        // 4: redirect during a memory wait is squashed
        Jump = 1'b1; JumpDest = 32'h20;
        cyc();
        Jump = 1'b0; IMemReady = 1'b0; #1;
        chk("t4_stall1", 32'(FetchStall), 32'd1);
        cyc();
        chk("t4_addr_w1", IMemAddr, 32'h20);
        Jump = 1'b1; JumpDest = 32'h80;
        cyc();
        Jump = 1'b0;
        chk("t4_addr_w2", IMemAddr, 32'h20); chk("t4_stall2", 32'(FetchStall), 32'd1);
        cyc();
        chk("t4_addr_w3", IMemAddr, 32'h20);
        IMemReady = 1'b1; #1;
        chk("t4_stall_rdy", 32'(FetchStall), 32'd0);
        cyc();
        chk("t4_addr80", IMemAddr, 32'h80); chk("t4_discard", 32'(IFIDValid), 32'd0);
        cyc();
        chk("t4_instr", Instruction, 32'h81); chk("t4_pc", PC_Out, 32'h80);

        // 5: stall into the hold buffer
        Jump = 1'b1; JumpDest = 32'hC;
        cyc();
        Jump = 1'b0;
        cyc();
        PC_WriteEnable = 1'b0; IFIDWriteEnable = 1'b0;
        cyc();
        chk("t5_req0", 32'(IMemReq), 32'd0); chk("t5_stall", 32'(FetchStall), 32'd1);
        chk("t5_hold_instr", Instruction, 32'hD); chk("t5_hold_pc", PC_Out, 32'hC);
        cyc();
        chk("t5_req0b", 32'(IMemReq), 32'd0); chk("t5_hold_instr2", Instruction, 32'hD);
        PC_WriteEnable = 1'b1; IFIDWriteEnable = 1'b1;
        cyc();
        chk("t5_instr", Instruction, 32'hAABB_CCDD); chk("t5_pc", PC_Out, 32'h10);
        chk("t5_addr", IMemAddr, 32'h14); chk("t5_req1", 32'(IMemReq), 32'd1);

        // 6: reset during a request, then during HOLD
        Reset = 1'b1; #1;
        chk("t6_req", 32'(IMemReq), 32'd0); chk("t6_nop", Instruction, 32'h0);
        chk("t6_valid", 32'(IFIDValid), 32'd0); chk("t6_addr", IMemAddr, 32'h0);
        cyc();
        Reset = 1'b0; #1;
        chk("t6_req_after", 32'(IMemReq), 32'd1);
        cyc();
        PC_WriteEnable = 1'b0;
        cyc();
        chk("t6_in_hold", 32'(IMemReq), 32'd0);
        PC_WriteEnable = 1'b1; Reset = 1'b1; #1;
        chk("t6_hold_req", 32'(IMemReq), 32'd0); chk("t6_hold_stall", 32'(FetchStall), 32'd0);
        cyc();
        Reset = 1'b0; #1;
        chk("t6_addr_rst", IMemAddr, 32'h0); chk("t6_req_rst", 32'(IMemReq), 32'd1);

        // PC wrap and unaligned target
        Jump = 1'b1; JumpDest = 32'hFFFF_FFFC;
        cyc();
        Jump = 1'b0;
        chk("wrap_addr", IMemAddr, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_addr0", IMemAddr, 32'h0); chk("wrap_instr", Instruction, 32'hFFFF_FFFD);
        chk("wrap_pc", PC_Out, 32'hFFFF_FFFC);
        Jump = 1'b1; JumpDest = 32'h103;
        cyc();
        Jump = 1'b0;
        chk("unal_addr", IMemAddr, 32'h100);
        cyc();
        chk("unal_instr", Instruction, 32'h101); chk("unal_pc", PC_Out, 32'h103);
        chk("unal_next", IMemAddr, 32'h104);
        IFIDWriteEnable = 1'b0;
        cyc();
        chk("idwe_hold_instr", Instruction, 32'h101); chk("idwe_hold_v", 32'(IFIDValid), 32'd1);
        IFIDWriteEnable = 1'b1;
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that feeds the decode stage. It owns the program counter, the instruction-memory request/response handshake and the IF/ID pipeline register. It accepts redirect and stall controls from decode (Branch/BranchDest, Jump/JumpDest, PC_WriteEnable, IFIDWriteEnable, IFIDFlush). It presents Instruction and PC_Out to decode; decode forms PC+4 from PC_Out.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on flush or reset (sll $0,$0,0).

Ports:
Clock  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-high reset.
PC_WriteEnable  in  1  decode permits the PC to advance; 0 = load-use stall.
IFIDWriteEnable  in  1  decode permits IF/ID to load; 0 = hold contents.
IFIDFlush  in  1  overwrite IF/ID with NOP_WORD at the next edge.
Branch  in  1  taken branch resolved in decode this cycle.
BranchDest  in  32  branch target.
Jump  in  1  jump (j/jal/jr) resolved in decode this cycle.
JumpDest  in  32  jump target.
IMemReq  out  1  fetch request to instruction memory.
IMemAddr  out  32  word address of the request, {PC[31:2],2'b00}.
IMemReady  in  1  memory accepts the request; IMemData is valid in the same cycle.
IMemData  in  32  fetched instruction word.
Instruction  out  32  IF/ID instruction register.
PC_Out  out  32  IF/ID register holding the address of Instruction.
IFIDValid  out  1  IF/ID holds a real fetched instruction, not a bubble.
FetchStall  out  1  high while IF/ID cannot be loaded with a new instruction (waiting on memory or holding a buffered word).

Behaviour:
- All registers are reset asynchronously. PC=RESET_PC, Instruction=NOP_WORD, PC_Out=0, IFIDValid=0, IMemReq=0 while Reset is high, state=REQ, squash flag=0, hold buffer=0.
- Redirect target: Jump has priority over Branch. redirect = Branch|Jump.
- FSM states:
  - REQ: IMemReq=1 and IMemAddr follows PC.
  - HOLD: IMemReq=0; the word is held in the hold buffer.
- REQ with IMemReady=1, first matching rule applies:
  (a) redirect: PC<=target, discard data, stay in REQ.
  (b) squash flag set: PC<=squash target, clear flag, discard data.
  (c) PC_WriteEnable & IFIDWriteEnable: IF/ID<={IMemData, PC}, IFIDValid<=1, PC<=PC+4. With zero-wait memory this gives 1 instruction per cycle.
  (d) otherwise: buffer<=IMemData, go to HOLD, PC is not changed.
- REQ with IMemReady=0:
  - IMemAddr must stay stable, so a redirect is not applied to the PC. Instead set the squash flag and latch the target; a later redirect overwrites the latched target.
  - IF/ID loads a bubble (NOP_WORD, IFIDValid=0) when IFIDWriteEnable=1; otherwise it holds.
- HOLD:
  - redirect: drop the buffer, PC<=target, go to REQ.
  - else if PC_WriteEnable & IFIDWriteEnable: IF/ID<={buffer, PC}, IFIDValid<=1, PC<=PC+4, go to REQ.
  - else remain in HOLD.
- IFIDFlush overrides every IF/ID load: Instruction<=NOP_WORD, IFIDValid<=0, PC_Out<=0.
- IFIDWriteEnable=0 without flush: IF/ID holds its value.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0. Target bits [1:0] are ignored in IMemAddr but kept in the PC.
- FetchStall = (state==HOLD) | (state==REQ & ~IMemReady).
- Reset asserted mid-request: IMemReq drops immediately. Instruction memory must tolerate an abandoned request.

Decomposition:
- Shared package holds the fetch state encoding (FETCH_REQ, FETCH_HOLD) and the NOP_WORD constant reused by the decode stage's flush logic.
- One natural sub-module: ifid_pipe_reg. It is the IF/ID register with write enable, flush and valid, instantiated once here.
- The FSM, PC, squash flag and hold buffer stay in if_fetch_unit.

Test Plan:
1. Reset release, IMemReady tied 1, memory returns addr+1 -> IMemAddr 0,4,8 on consecutive cycles; Instruction 1,5,9 and PC_Out 0,4,8 one cycle later; IFIDValid=1.
2. PC=0x40, Branch=1, BranchDest=0x100, IFIDFlush=1 -> next cycle IMemAddr=0x100, Instruction=NOP_WORD, IFIDValid=0; the word for 0x40 never reaches IF/ID.
3. Jump=1 (JumpDest=0x200) and Branch=1 (BranchDest=0x300) in the same cycle -> next IMemAddr=0x200.
4. IMemReady low 3 cycles at PC=0x20, Jump to 0x80 in wait cycle 2 -> IMemAddr stays 0x20 until ready; the returned word is discarded; next request is 0x80; FetchStall high during the wait.
5. PC_WriteEnable=IFIDWriteEnable=0 for 2 cycles while memory returns 0xAABBCCDD for 0x10 -> state HOLD, IMemReq=0, IF/ID unchanged. On release Instruction=0xAABBCCDD, PC_Out=0x10, next IMemAddr=0x14.
6. Reset pulsed while IMemReq=1 and in HOLD -> IMemReq=0 immediately, Instruction=NOP_WORD, IFIDValid=0; first post-reset IMemAddr=RESET_PC.
